// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern constants, bit indices and decode result type
package seg7_pkg;

  typedef enum logic [2:0] {
    SEG_A = 3'd0, SEG_B = 3'd1, SEG_C = 3'd2, SEG_D = 3'd3,
    SEG_E = 3'd4, SEG_F = 3'd5, SEG_G = 3'd6
  } seg_bit_e;

  // Active-low patterns, written g..a (bit6..bit0)
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_HA    = 7'b0001000;
  localparam logic [6:0] SEG_HB    = 7'b0000011;
  localparam logic [6:0] SEG_HC    = 7'b1000110;
  localparam logic [6:0] SEG_HD    = 7'b0100001;
  localparam logic [6:0] SEG_HE    = 7'b0000110;
  localparam logic [6:0] SEG_HF    = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] nibble;
    logic       err;
    logic       blank;
  } seg7_dec_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] pat;
    case (hex)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_HA;
      4'hB: pat = SEG_HB;
      4'hC: pat = SEG_HC;
      4'hD: pat = SEG_HD;
      4'hE: pat = SEG_HE;
      default: pat = SEG_HF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational active-low segment pattern to nibble/err/blank decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output seg7_dec_t  dec
);

  always_comb begin
    dec = '{nibble: 4'h0, err: 1'b1, blank: 1'b0};
    case (seg)
      SEG_0:     dec = '{nibble: 4'h0, err: 1'b0, blank: 1'b0};
      SEG_1:     dec = '{nibble: 4'h1, err: 1'b0, blank: 1'b0};
      SEG_2:     dec = '{nibble: 4'h2, err: 1'b0, blank: 1'b0};
      SEG_3:     dec = '{nibble: 4'h3, err: 1'b0, blank: 1'b0};
      SEG_4:     dec = '{nibble: 4'h4, err: 1'b0, blank: 1'b0};
      SEG_5:     dec = '{nibble: 4'h5, err: 1'b0, blank: 1'b0};
      SEG_6:     dec = '{nibble: 4'h6, err: 1'b0, blank: 1'b0};
      SEG_7:     dec = '{nibble: 4'h7, err: 1'b0, blank: 1'b0};
      SEG_8:     dec = '{nibble: 4'h8, err: 1'b0, blank: 1'b0};
      SEG_9:     dec = '{nibble: 4'h9, err: 1'b0, blank: 1'b0};
      SEG_HA:    dec = '{nibble: 4'hA, err: 1'b0, blank: 1'b0};
      SEG_HB:    dec = '{nibble: 4'hB, err: 1'b0, blank: 1'b0};
      SEG_HC:    dec = '{nibble: 4'hC, err: 1'b0, blank: 1'b0};
      SEG_HD:    dec = '{nibble: 4'hD, err: 1'b0, blank: 1'b0};
      SEG_HE:    dec = '{nibble: 4'hE, err: 1'b0, blank: 1'b0};
      SEG_HF:    dec = '{nibble: 4'hF, err: 1'b0, blank: 1'b0};
      SEG_BLANK: dec = '{nibble: 4'h0, err: 1'b0, blank: 1'b1};
      default:   dec = '{nibble: 4'h0, err: 1'b1, blank: 1'b0};
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - glitch-filtered multiplexed 7-segment bus monitor publishing whole scan frames
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NDIGITS       = 4,
  parameter int STABLE_CYCLES = 8
)(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             seg_in,
  input  logic [NDIGITS-1:0]     dig_sel,
  output logic [4*NDIGITS-1:0]   value,
  output logic                   value_valid,
  output logic [NDIGITS-1:0]     digit_err,
  output logic [NDIGITS-1:0]     blank
);

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HELD   = 1'b1;
  localparam logic [7:0] CNT_MAX   = 8'(STABLE_CYCLES - 1);
  // Capture fires on the edge where cnt would reach CNT_MAX
  localparam logic [7:0] CNT_CAP   = 8'(STABLE_CYCLES - 2);

  logic [6:0]           seg_s1, seg_s2;
  logic [NDIGITS-1:0]   sel_s1, sel_s2;
  logic [NDIGITS+6:0]   samp, samp_prev;
  logic [7:0]           cnt;
  logic [0:0]           state;
  logic                 stable, capture, frame_full;
  logic [NDIGITS-1:0]   mask;
  logic [4*NDIGITS-1:0] shadow_val;
  logic [NDIGITS-1:0]   shadow_err, shadow_blank;
  seg7_dec_t            dec;

  assign samp       = {sel_s2, seg_s2};
  assign stable     = (samp == samp_prev) && $onehot(sel_s2);
  assign capture    = (state == ST_SETTLE) && stable && (cnt == CNT_CAP);
  assign frame_full = &mask;

  seg7_decode u_decode (
    .seg (seg_s2),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1    <= SEG_BLANK;
      seg_s2    <= SEG_BLANK;
      sel_s1    <= '0;
      sel_s2    <= '0;
      samp_prev <= {{NDIGITS{1'b0}}, SEG_BLANK};
      cnt       <= '0;
      state     <= ST_SETTLE;
    end else begin
      seg_s1    <= seg_in;
      seg_s2    <= seg_s1;
      sel_s1    <= dig_sel;
      sel_s2    <= sel_s1;
      samp_prev <= samp;
      if (!stable)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 8'd1;
      case (state)
        ST_SETTLE: if (capture) state <= ST_HELD;
        default:   if (!stable) state <= ST_SETTLE;
      endcase
    end
  end

  // A capture in the publish cycle lands in the freshly cleared mask
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask         <= '0;
      shadow_val   <= '0;
      shadow_err   <= '0;
      shadow_blank <= '0;
      value        <= '0;
      value_valid  <= 1'b0;
      digit_err    <= '0;
      blank        <= '0;
    end else begin
      value_valid <= 1'b0;
      if (frame_full) begin
        value       <= shadow_val;
        digit_err   <= shadow_err;
        blank       <= shadow_blank;
        value_valid <= 1'b1;
      end
      if (capture) begin
        mask <= (frame_full ? '0 : mask) | sel_s2;
        for (int i = 0; i < NDIGITS; i++) begin
          if (sel_s2[i]) begin
            shadow_val[4*i +: 4] <= dec.nibble;
            shadow_err[i]        <= dec.err;
            shadow_blank[i]      <= dec.blank;
          end
        end
      end else if (frame_full) begin
        mask <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  digit_err;
  logic [3:0]  blank;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int pulses = 0;
  int doubles = 0;
  int last_cyc = 0;
  int t_last = 0;
  logic        prev_vv = 1'b0;
  logic [15:0] got_val = '0;
  logic [3:0]  got_err = '0;
  logic [3:0]  got_blank = '0;

  seg7_scan_decoder #(.NDIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .value       (value),
    .value_valid (value_valid),
    .digit_err   (digit_err),
    .blank       (blank)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (value_valid) begin
      pulses++;
      last_cyc  = cyc;
      got_val   = value;
      got_err   = digit_err;
      got_blank = blank;
      if (prev_vv) doubles++;
    end
    prev_vv = value_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input int d, input logic [6:0] pat, input int n);
    dig_sel = 4'b0001 << d;
    seg_in  = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic last_dwell(input int d, input logic [6:0] pat);
    t_last = cyc;
    dwell(d, pat, 10);
  endtask

  task automatic gap(input int n);
    dig_sel = 4'b0000;
    seg_in  = 7'b1111111;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] ev, input logic [3:0] ee,
                             input logic [3:0] eb);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_value"}, 32'(got_val), 32'(ev));
    check({tag, "_err"}, 32'(got_err), 32'(ee));
    check({tag, "_blank"}, 32'(got_blank), 32'(eb));
    check({tag, "_latency"}, last_cyc, t_last + 7);
    pulses = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    seg_in  = 7'b1111111;
    dig_sel = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 0);
    check("rst_valid", 32'(value_valid), 0);
    check("rst_err", 32'(digit_err), 0);
    check("rst_blank", 32'(blank), 0);
    rst_n = 1'b1;
    gap(3);

    // 3,A,7,F
    dwell(0, 7'b0110000, 10);
    dwell(1, 7'b0001000, 10);
    dwell(2, 7'b1111000, 10);
    last_dwell(3, 7'b0001110);
    check_frame("basic", 16'hF7A3, 4'b0000, 4'b0000);
    gap(3);

    // 1,5,<bad>,8
    dwell(0, 7'b1111001, 10);
    dwell(1, 7'b0010010, 10);
    dwell(2, 7'b1010101, 10);
    last_dwell(3, 7'b0000000);
    check_frame("bad_pat", 16'h8051, 4'b0100, 4'b0000);
    gap(3);

    // 2,<blank>,9,C
    dwell(0, 7'b0100100, 10);
    dwell(1, 7'b1111111, 10);
    dwell(2, 7'b0010000, 10);
    last_dwell(3, 7'b1000110);
    check_frame("blank", 16'hC902, 4'b0000, 4'b0010);
    gap(3);

    // digit 0 shows 5, glitches to 8 for 3 cycles, settles on 5
    dwell(0, 7'b0010010, 3);
    dwell(0, 7'b0000000, 3);
    dwell(0, 7'b0010010, 10);
    dwell(1, 7'b0000010, 10);
    dwell(2, 7'b0100001, 10);
    last_dwell(3, 7'b0000110);
    check_frame("glitch", 16'hED65, 4'b0000, 4'b0000);
    gap(3);

    // two-hot select must not fill digits 1/2
    dwell(0, 7'b0011001, 10);
    gap(4);
    dwell(3, 7'b1111001, 10);
    dig_sel = 4'b0110;
    seg_in  = 7'b1111000;
    repeat (20) @(negedge clk);
    gap(4);
    check("multi_hot_no_publish", pulses, 0);
    dwell(1, 7'b0000011, 10);
    gap(4);
    last_dwell(2, 7'b1000000);
    check_frame("multi_hot", 16'h10B4, 4'b0000, 4'b0000);
    gap(3);

    // reset after a partial frame
    dwell(0, 7'b0010000, 10);
    dwell(1, 7'b0010000, 10);
    rst_n   = 1'b0;
    dig_sel = 4'b0000;
    seg_in  = 7'b1111111;
    @(negedge clk);
    check("midrst_value", 32'(value), 0);
    check("midrst_valid", 32'(value_valid), 0);
    check("midrst_err", 32'(digit_err), 0);
    check("midrst_blank", 32'(blank), 0);
    rst_n = 1'b1;
    gap(3);
    dwell(2, 7'b0110000, 10);
    dwell(3, 7'b0011001, 10);
    check("midrst_no_stale", pulses, 0);
    dwell(0, 7'b1111001, 10);
    last_dwell(1, 7'b0100100);
    check_frame("after_rst", 16'h4321, 4'b0000, 4'b0000);
    gap(3);

    check("pulse_width", doubles, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
